// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake and a pass-through tag.
// The log2 barrel is cut into register banks of REG_EVERY levels each; a stall freezes the whole pipe.
module shift_unit_pipe #(
   parameter int WIDTH     = 32,
   parameter int SHAMT_W   = $clog2(WIDTH),
   parameter int REG_EVERY = 1,
   parameter int TAG_W     = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_zero
);

   localparam int NSTAGE = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } shiftOp_e;

   logic               w_advance;
   logic [WIDTH-1:0]   w_inData;
   logic [SHAMT_W-1:0] w_inShamt;
   logic [1:0]         w_inOp;
   logic [TAG_W-1:0]   w_inTag;

   logic               r_valid [NSTAGE];
   logic [WIDTH-1:0]   r_data  [NSTAGE];
   logic [SHAMT_W-1:0] r_shamt [NSTAGE];
   logic [1:0]         r_op    [NSTAGE];
   logic               r_sign  [NSTAGE];
   logic [TAG_W-1:0]   r_tag   [NSTAGE];
   logic               r_zero;

   logic               w_stValid    [NSTAGE];
   logic [WIDTH-1:0]   w_stData     [NSTAGE];
   logic [SHAMT_W-1:0] w_stShamt    [NSTAGE];
   logic [1:0]         w_stOp       [NSTAGE];
   logic               w_stSign     [NSTAGE];
   logic [TAG_W-1:0]   w_stTag      [NSTAGE];
   logic [WIDTH-1:0]   w_bankNext   [NSTAGE];
   logic [SHAMT_W-1:0] w_shamtLeft  [NSTAGE];

   assign w_advance = !r_valid[NSTAGE-1] || out_ready;
   assign in_ready  = w_advance;

   // Idle inputs are forced to zero so an undriven operand never leaks X into the pipe.
   assign w_inData  = in_valid ? in_data  : '0;
   assign w_inShamt = in_valid ? in_shamt : '0;
   assign w_inOp    = in_valid ? in_op    : '0;
   assign w_inTag   = in_valid ? in_tag   : '0;

   for (genvar s = 0; s < NSTAGE; s++) begin : gStage
      localparam int FIRST = s * REG_EVERY;
      localparam int LAST  = (((s + 1) * REG_EVERY) < SHAMT_W) ? ((s + 1) * REG_EVERY - 1) : (SHAMT_W - 1);
      localparam logic [SHAMT_W-1:0] USED_MASK = SHAMT_W'((1 << (LAST + 1)) - 1);

      logic [WIDTH-1:0] w_acc;

      if (s == 0) begin : gFromInput
         assign w_stValid[s] = in_valid;
         assign w_stData[s]  = w_inData;
         assign w_stShamt[s] = w_inShamt;
         assign w_stOp[s]    = w_inOp;
         assign w_stSign[s]  = w_inData[WIDTH-1];
         assign w_stTag[s]   = w_inTag;
      end else begin : gFromBank
         assign w_stValid[s] = r_valid[s-1];
         assign w_stData[s]  = r_data[s-1];
         assign w_stShamt[s] = r_shamt[s-1];
         assign w_stOp[s]    = r_op[s-1];
         assign w_stSign[s]  = r_sign[s-1];
         assign w_stTag[s]   = r_tag[s-1];
      end

      // Levels FIRST..LAST of the barrel, LSB level first; level k moves the word by 2^k.
      always_comb begin
         w_acc = w_stData[s];
         for (int k = FIRST; k <= LAST; k++) begin
            if ((w_stShamt[s] & (SHAMT_W'(1) << k)) != '0) begin
               case (w_stOp[s])
                  OP_SLL:  w_acc = w_acc << (1 << k);
                  OP_SRL:  w_acc = w_acc >> (1 << k);
                  OP_SRA:  w_acc = (w_acc >> (1 << k)) |
                                   (w_stSign[s] ? ~({WIDTH{1'b1}} >> (1 << k)) : '0);
                  default: w_acc = (w_acc >> (1 << k)) | (w_acc << (WIDTH - (1 << k)));
               endcase
            end
         end
      end

      assign w_bankNext[s]  = w_acc;
      assign w_shamtLeft[s] = w_stShamt[s] & ~USED_MASK;
   end

   // Every bank moves together on advance and holds otherwise, so the output stays stable under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NSTAGE; s++) begin
            r_valid[s] <= 1'b0;
            r_data[s]  <= '0;
            r_shamt[s] <= '0;
            r_op[s]    <= '0;
            r_sign[s]  <= 1'b0;
            r_tag[s]   <= '0;
         end
         r_zero <= 1'b0;
      end else if (w_advance) begin
         for (int s = 0; s < NSTAGE; s++) begin
            r_valid[s] <= w_stValid[s];
            r_data[s]  <= w_bankNext[s];
            r_shamt[s] <= w_shamtLeft[s];
            r_op[s]    <= w_stOp[s];
            r_sign[s]  <= w_stSign[s];
            r_tag[s]   <= w_stTag[s];
         end
         r_zero <= w_stValid[NSTAGE-1] && (w_bankNext[NSTAGE-1] == '0);
      end
   end

   assign out_valid = r_valid[NSTAGE-1];
   assign out_data  = r_data[NSTAGE-1];
   assign out_tag   = r_tag[NSTAGE-1];
   assign out_zero  = r_zero;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe (32-bit, one level per stage) plus randomised
// reference-model sweeps of the 8-bit/L=1 and 64-bit/L=3 configurations.
module tb_shift_unit_pipe;

   logic        clk = 1'b0;
   logic        rstN;
   logic        inValid;
   logic        inReady;
   logic [31:0] inData;
   logic [4:0]  inShamt;
   logic [1:0]  inOp;
   logic [4:0]  inTag;
   logic        outValid;
   logic        outReady;
   logic [31:0] outData;
   logic [4:0]  outTag;
   logic        outZero;

   logic        sweepSel;
   logic        gValid;
   logic [63:0] gData;
   logic [5:0]  gShamt;
   logic [1:0]  gOp;
   logic [4:0]  gTag;
   logic        gOutReady;
   logic        o8Ready, o8Valid, o8Zero;
   logic [7:0]  o8Data;
   logic [4:0]  o8Tag;
   logic        o64Ready, o64Valid, o64Zero;
   logic [63:0] o64Data;
   logic [4:0]  o64Tag;
   logic        sweepInReady, sweepOutValid, sweepOutZero;
   logic [63:0] sweepOutData;
   logic [4:0]  sweepOutTag;

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   shift_unit_pipe #(.WIDTH(32), .REG_EVERY(1), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rstN),
      .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_shamt(inShamt),
      .in_op(inOp), .in_tag(inTag),
      .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_tag(outTag),
      .out_zero(outZero)
   );

   shift_unit_pipe #(.WIDTH(8), .REG_EVERY(3), .TAG_W(5)) dut8 (
      .clk(clk), .rst_n(rstN),
      .in_valid(gValid & ~sweepSel), .in_ready(o8Ready), .in_data(gData[7:0]),
      .in_shamt(gShamt[2:0]), .in_op(gOp), .in_tag(gTag),
      .out_valid(o8Valid), .out_ready(gOutReady), .out_data(o8Data), .out_tag(o8Tag),
      .out_zero(o8Zero)
   );

   shift_unit_pipe #(.WIDTH(64), .REG_EVERY(2), .TAG_W(5)) dut64 (
      .clk(clk), .rst_n(rstN),
      .in_valid(gValid & sweepSel), .in_ready(o64Ready), .in_data(gData),
      .in_shamt(gShamt), .in_op(gOp), .in_tag(gTag),
      .out_valid(o64Valid), .out_ready(gOutReady), .out_data(o64Data), .out_tag(o64Tag),
      .out_zero(o64Zero)
   );

   assign sweepInReady  = sweepSel ? o64Ready : o8Ready;
   assign sweepOutValid = sweepSel ? o64Valid : o8Valid;
   assign sweepOutData  = sweepSel ? o64Data  : {56'b0, o8Data};
   assign sweepOutTag   = sweepSel ? o64Tag   : o8Tag;
   assign sweepOutZero  = sweepSel ? o64Zero  : o8Zero;

   // Bit-by-bit reference shifter, deliberately unlike the barrel structure.
   function automatic logic [63:0] refShift(input logic [63:0] d, input int sh,
                                            input logic [1:0] op, input int w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         case (op)
            2'b00:   r[i] = (i >= sh) ? d[i-sh] : 1'b0;
            2'b01:   r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
            2'b10:   r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
            default: r[i] = d[(i + sh) % w];
         endcase
      end
      return r;
   endfunction

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] sh,
                                input logic [1:0] op, input logic [4:0] tag);
      inValid = v;
      inData  = d;
      inShamt = sh;
      inOp    = op;
      inTag   = tag;
   endtask

   // Push one op into an idle pipe and report what came out and after how many edges.
   task automatic runOne(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                         input logic [4:0] tag, output logic [31:0] gotData,
                         output logic [4:0] gotTag, output logic gotZero, output int lat);
      @(negedge clk);
      outReady = 1'b1;
      applyStimulus(1'b1, d, sh, op, tag);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 5'h0, 2'b00, 5'h0);
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         if (outValid) begin
            lat = n;
            break;
         end
         @(negedge clk);
      end
      gotData = outData;
      gotTag  = outTag;
      gotZero = outZero;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [4:0]  t;
      logic        z;
      int          lat;
      rstN     = 1'b0;
      outReady = 1'b0;
      applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd3, 2'b01, 5'd9);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         testsRun++;
         if (outValid !== 1'b0 || outData !== 32'h0 || outTag !== 5'h0 || outZero !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h tag=%h zero=%b, want 0/0/0/0",
                     outValid, outData, outTag, outZero);
         end
         testsRun++;
         if (inReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_ready: got %b, want 1", inReady);
         end
      end
      applyStimulus(1'b0, 32'h0, 5'h0, 2'b00, 5'h0);
      rstN = 1'b1;
      runOne(32'h1234_5678, 5'd8, 2'b00, 5'd3, d, t, z, lat);
      testsRun++;
      if (lat !== 5 || d !== 32'h3456_7800 || t !== 5'd3) begin
         testsFailed++;
         $display("[TB] FAIL reset_first_op: got lat=%0d data=%h tag=%0d, want lat=5 data=34567800 tag=3",
                  lat, d, t);
      end
   endtask

   task automatic test_modes();
      logic [31:0] expM [4];
      logic [31:0] d;
      logic [4:0]  t;
      logic        z;
      int          lat;
      expM[0] = 32'h0000_0F10;
      expM[1] = 32'h0800_000F;
      expM[2] = 32'hF800_000F;
      expM[3] = 32'h1800_000F;
      for (int m = 0; m < 4; m++) begin
         runOne(32'h8000_00F1, 5'd4, m[1:0], 5'(m + 10), d, t, z, lat);
         testsRun++;
         if (d !== expM[m]) begin
            testsFailed++;
            $display("[TB] FAIL mode_data op=%0d: got %h, want %h", m, d, expM[m]);
         end
         testsRun++;
         if (t !== 5'(m + 10)) begin
            testsFailed++;
            $display("[TB] FAIL mode_tag op=%0d: got %0d, want %0d", m, t, m + 10);
         end
         testsRun++;
         if (lat !== 5) begin
            testsFailed++;
            $display("[TB] FAIL mode_latency op=%0d: got %0d, want 5", m, lat);
         end
      end
   endtask

   task automatic test_edges();
      logic [1:0]  eOp  [7];
      logic [4:0]  eSh  [7];
      logic [31:0] eExp [7];
      logic        eZ   [7];
      logic [31:0] d;
      logic [4:0]  t;
      logic        z;
      int          lat;
      eOp[0] = 2'b10; eSh[0] = 5'd31; eExp[0] = 32'hFFFF_FFFF; eZ[0] = 1'b0;
      eOp[1] = 2'b01; eSh[1] = 5'd31; eExp[1] = 32'h0000_0001; eZ[1] = 1'b0;
      eOp[2] = 2'b00; eSh[2] = 5'd1;  eExp[2] = 32'h0000_0000; eZ[2] = 1'b1;
      for (int m = 0; m < 4; m++) begin
         eOp[3+m] = m[1:0]; eSh[3+m] = 5'd0; eExp[3+m] = 32'h8000_0000; eZ[3+m] = 1'b0;
      end
      for (int e = 0; e < 7; e++) begin
         runOne(32'h8000_0000, eSh[e], eOp[e], 5'(e), d, t, z, lat);
         testsRun++;
         if (d !== eExp[e] || z !== eZ[e] || t !== 5'(e) || lat !== 5) begin
            testsFailed++;
            $display("[TB] FAIL edge_%0d op=%0d sh=%0d: got data=%h zero=%b tag=%0d lat=%0d, want data=%h zero=%b tag=%0d lat=5",
                     e, eOp[e], eSh[e], d, z, t, lat, eExp[e], eZ[e], e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] expB [8];
      int          got;
      int          extra;
      for (int i = 0; i < 8; i++) expB[i] = 32'h0000_00A5 << i;
      got = 0;
      @(negedge clk);
      outReady = 1'b0;
      fork
         begin
            int   idx   = 0;
            int   guard = 0;
            logic acc;
            while (idx < 8 && guard < 100) begin
               @(negedge clk);
               #2;
               applyStimulus(1'b1, 32'h0000_00A5, 5'(idx), 2'b00, 5'(idx));
               #1;
               acc = inReady;
               @(posedge clk);
               if (acc) idx++;
               guard++;
            end
            @(negedge clk);
            #2;
            applyStimulus(1'b0, 32'h0, 5'h0, 2'b00, 5'h0);
         end
         begin
            int          stallLeft = 3;
            int          guard     = 0;
            logic [31:0] holdData  = '0;
            logic [4:0]  holdTag   = '0;
            while (got < 8 && guard < 100) begin
               @(negedge clk);
               #1;
               if (outValid && stallLeft > 0) begin
                  testsRun++;
                  if (inReady !== 1'b0) begin
                     testsFailed++;
                     $display("[TB] FAIL stall_in_ready: got %b, want 0", inReady);
                  end
                  if (stallLeft == 3) begin
                     holdData = outData;
                     holdTag  = outTag;
                  end else begin
                     testsRun++;
                     if (outData !== holdData || outTag !== holdTag) begin
                        testsFailed++;
                        $display("[TB] FAIL stall_stable: got data=%h tag=%0d, want data=%h tag=%0d",
                                 outData, outTag, holdData, holdTag);
                     end
                  end
                  stallLeft--;
               end else if (outValid) begin
                  outReady = 1'b1;
                  testsRun++;
                  if (outData !== expB[got] || outTag !== 5'(got)) begin
                     testsFailed++;
                     $display("[TB] FAIL b2b_result_%0d: got data=%h tag=%0d, want data=%h tag=%0d",
                              got, outData, outTag, expB[got], got);
                  end
                  got++;
               end
               guard++;
            end
         end
      join
      testsRun++;
      if (got != 8) begin
         testsFailed++;
         $display("[TB] FAIL b2b_count: got %0d results, want 8", got);
      end
      extra = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (outValid) extra++;
      end
      testsRun++;
      if (extra != 0) begin
         testsFailed++;
         $display("[TB] FAIL b2b_duplicates: got %0d extra valid cycles, want 0", extra);
      end
   endtask

   task automatic test_reset_midflight();
      int          ghosts;
      logic [31:0] d;
      logic [4:0]  t;
      logic        z;
      int          lat;
      @(negedge clk);
      outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h0000_0F00, 5'(i + 1), 2'b01, 5'(20 + i));
         @(posedge clk);
         @(negedge clk);
      end
      applyStimulus(1'b0, 32'h0, 5'h0, 2'b00, 5'h0);
      rstN = 1'b0;
      ghosts = 0;
      @(negedge clk);
      if (outValid) ghosts++;
      rstN = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (outValid) ghosts++;
      end
      testsRun++;
      if (ghosts != 0) begin
         testsFailed++;
         $display("[TB] FAIL midflight_discard: got %0d valid cycles, want 0", ghosts);
      end
      runOne(32'hC000_0003, 5'd2, 2'b11, 5'd30, d, t, z, lat);
      testsRun++;
      if (d !== 32'hF000_0000 || t !== 5'd30 || lat !== 5) begin
         testsFailed++;
         $display("[TB] FAIL midflight_next_op: got data=%h tag=%0d lat=%0d, want data=f0000000 tag=30 lat=5",
                  d, t, lat);
      end
   endtask

   typedef struct {
      logic [63:0] expData;
      logic [4:0]  tag;
      int          acc;
      int          stl;
   } sbEntry_t;

   task automatic test_param_sweep(input logic sel);
      localparam int NOPS = 10000;
      localparam int MAXC = 80000;
      sbEntry_t    sbQ [$];
      sbEntry_t    ent;
      int          w, lat, shw, cycle, stalls, sent, recv;
      logic        pending, headSeen;
      logic [63:0] mask, expD;
      sweepSel  = sel;
      w         = sel ? 64 : 8;
      lat       = sel ? 3 : 1;
      shw       = sel ? 6 : 3;
      mask      = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
      cycle     = 0;
      stalls    = 0;
      sent      = 0;
      recv      = 0;
      pending   = 1'b0;
      headSeen  = 1'b0;
      gValid    = 1'b0;
      gOutReady = 1'b0;
      @(negedge clk);
      while (recv < NOPS && cycle < MAXC) begin
         if (!pending) begin
            gValid = (sent < NOPS) && ($urandom_range(0, 3) != 0);
            gData  = {$urandom, $urandom};
            gShamt = 6'($urandom_range(0, w - 1));
            gOp    = 2'($urandom_range(0, 3));
            gTag   = 5'(sent);
         end
         gOutReady = ($urandom_range(0, 3) != 0);
         #1;
         if (sweepOutValid && sbQ.size() > 0 && !headSeen) begin
            headSeen = 1'b1;
            if (stalls == sbQ[0].stl) begin
               testsRun++;
               if (cycle - sbQ[0].acc != lat) begin
                  testsFailed++;
                  $display("[TB] FAIL sweep%0d_latency tag=%0d: got %0d, want %0d",
                           w, sbQ[0].tag, cycle - sbQ[0].acc, lat);
               end
            end
         end
         if (sweepOutValid && gOutReady) begin
            testsRun++;
            if (sbQ.size() == 0) begin
               testsFailed++;
               $display("[TB] FAIL sweep%0d_unexpected: got data=%h tag=%0d, want no result",
                        w, sweepOutData, sweepOutTag);
            end else begin
               ent = sbQ.pop_front();
               if ((sweepOutData & mask) !== ent.expData || sweepOutTag !== ent.tag ||
                   sweepOutZero !== (ent.expData == 64'h0)) begin
                  testsFailed++;
                  $display("[TB] FAIL sweep%0d_result: got data=%h tag=%0d zero=%b, want data=%h tag=%0d zero=%b",
                           w, sweepOutData, sweepOutTag, sweepOutZero, ent.expData, ent.tag,
                           ent.expData == 64'h0);
               end
            end
            headSeen = 1'b0;
            recv++;
         end
         if (!sweepInReady) stalls++;
         if (gValid && sweepInReady) begin
            expD        = refShift(gData & mask, int'(gShamt), gOp, w);
            ent.expData = expD;
            ent.tag     = gTag;
            ent.acc     = cycle;
            ent.stl     = stalls;
            sbQ.push_back(ent);
            sent++;
            pending = 1'b0;
         end else begin
            pending = gValid;
         end
         @(negedge clk);
         cycle++;
      end
      gValid    = 1'b0;
      gOutReady = 1'b1;
      testsRun++;
      if (recv != NOPS) begin
         testsFailed++;
         $display("[TB] FAIL sweep%0d_count: got %0d results, want %0d", w, recv, NOPS);
      end
   endtask

   initial begin
      sweepSel  = 1'b0;
      gValid    = 1'b0;
      gData     = '0;
      gShamt    = '0;
      gOp       = '0;
      gTag      = '0;
      gOutReady = 1'b1;
      test_reset();
      test_modes();
      test_edges();
      test_back_to_back();
      test_reset_midflight();
      test_param_sweep(1'b0);
      test_param_sweep(1'b1);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the single-cycle 32-bit logical-left shifter in the ALU path.
- Supports four shift modes, a generic data width, configurable pipeline depth, and a valid/ready handshake.
- Carries a tag for the destination register or ROB id, so the block can serve a multi-cycle or pipelined datapath.
- Sits between the decode/operand-fetch stage and writeback, beside the ALU.

Parameters:
- WIDTH, 32, data width in bits. Must be a power of two and ≥8.
- SHAMT_W, log2(WIDTH), shift-amount width. Derived; do not override.
- REG_EVERY, 1, number of mux levels per pipeline stage. Range 1..SHAMT_W.
- TAG_W, 5, width of the pass-through tag.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block accepts the input this cycle
- in_data  in  WIDTH  operand to shift
- in_shamt  in  SHAMT_W  shift amount (use rt/shamt field or rs[SHAMT_W-1:0])
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
- in_tag  in  TAG_W  opaque tag, returned with the result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of out_data
- out_zero  out  1  out_data == 0

Behaviour:
- Datapath structure:
  - log2 barrel of SHAMT_W levels. Level k shifts by 2^k when shamt bit k is set.
  - LSB level is applied first.
  - A register bank is placed after every REG_EVERY levels, plus after the final level.
  - Latency L = ceil(SHAMT_W / REG_EVERY) cycles from accept to out_valid. WIDTH=32, REG_EVERY=1 gives L=5.
- Operation semantics:
  - Shift amount is in_shamt modulo WIDTH. Shifts ≥WIDTH cannot occur.
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: in_data[WIDTH-1] fill.
  - ROR: bits leaving at the LSB re-enter at the MSB.
  - shamt=0 returns in_data unchanged in all modes.
- Per-stage state: valid bit, partial data, remaining shamt bits, op, sign bit (captured at accept), and tag.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational; no dependency on in_valid).
  - When advance=1, all stages shift one step together. Stage 0 loads the input; its valid bit = in_valid.
  - When advance=0, all stage registers hold their values. out_data, out_tag and out_zero stay stable while out_valid && !out_ready.
  - Bubbles are not collapsed. A stall freezes the whole pipe.
  - Throughput is one result per cycle when out_ready=1 continuously.
- out_zero is registered alongside out_data and is computed from the final-level value.
- Reset:
  - While rst_n=0, all valid bits, data, tag and shamt registers are 0, so out_valid=0, out_data=0, out_tag=0 and out_zero=0.
  - in_ready=1 immediately after reset.
  - Reset mid-operation discards all in-flight operations; no partial result is ever presented.
- Boundary cases:
  - in_valid=1 with in_ready=0: the input is not captured. The producer must hold it until in_ready=1.
  - Simultaneous output pop and input push in the same cycle is legal and loses nothing.
  - SRA on a negative operand with shamt=WIDTH-1 yields all ones.
  - ROR with shamt=0 is the identity.
- No X-propagation from in_data is allowed when in_valid=0. Idle stages are still clocked but are masked by their valid bits.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while driving in_valid=1 → out_valid=0, out_data=0, in_ready=1. Release reset; the first op appears exactly L cycles after accept.
- Modes, WIDTH=32, REG_EVERY=1, in_data=0x8000_00F1, shamt=4:
  - SLL → 0x0000_0F10
  - SRL → 0x0800_000F
  - SRA → 0xF800_000F
  - ROR → 0x1800_000F
- Each result appears with its tag 5 cycles after accept.
- Edge amounts, in_data=0x8000_0000:
  - SRA shamt=31 → 0xFFFF_FFFF
  - SRL shamt=31 → 0x0000_0001, out_zero=0
  - SLL shamt=1 → 0x0000_0000, out_zero=1
  - shamt=0 in all modes → 0x8000_0000
- Back-to-back with stall:
  - Stream 8 ops on consecutive cycles with tags 0..7.
  - Hold out_ready=0 for 3 cycles after the first out_valid: in_ready=0 during the stall and out_data/out_tag stay stable.
  - All 8 results arrive in order, tags 0..7, with none lost or duplicated.
- Reset mid-flight: accept 3 ops, assert rst_n=0 for 1 cycle at cycle 2 → none of the 3 ops ever produces out_valid. A new op after reset completes normally.
- Parameter sweep: WIDTH=8/REG_EVERY=3 (L=1) and WIDTH=64/REG_EVERY=2 (L=3). Run 10k random ops with random out_ready against a reference model → zero mismatches; latency equals L whenever no stall occurs.
